bcd_scan_ctrl: RTL and testbench
================================

BCD_SCAN_CTRL -- requirements
Module: bcd_scan_ctrl

Interface
REQ-001 Parameter N, default 10: binary input width; legal range 4..14.
REQ-002 Parameter DIV, default 50000: scan prescaler period in clk cycles; legal range 2..2^20.
REQ-003 clk  input  1: single clock; all state updates on its rising edge.
REQ-004 rst  input  1: synchronous, active-high reset.
REQ-005 start  input  1: conversion request, sampled every cycle.
REQ-006 bin_in  input  N: unsigned binary value, captured on accepted start.
REQ-007 busy  output  1: high while a conversion is in progress.
REQ-008 done  output  1: one-cycle pulse when a new result is committed.
REQ-009 overflow  output  1: captured value exceeded 9999; holds until next commit.
REQ-010 bcd_out  output  16: committed result {thousands, hundreds, tens, units}, 4 bits each.
REQ-011 digit_code  output  4: BCD digit of the currently scanned position, drives the team's 7-segment decoder.
REQ-012 digit_sel  output  4: active-low one-hot digit enable; bit0 units ... bit3 thousands.

Function
REQ-013 FSM SHALL have states IDLE, SHIFT, COMMIT.
REQ-014 IDLE: start=1 SHALL capture bin_in into a shift register, clear the 16-bit BCD scratch, load bit counter with N, and go to SHIFT; start=0 SHALL stay in IDLE.
REQ-015 SHIFT: each cycle, every scratch nibble >=5 SHALL get +3, then {scratch, shift} SHALL shift left by one, with the shift MSB entering scratch bit0; the counter decrements.
REQ-016 After the N-th SHIFT cycle, the FSM SHALL go to COMMIT.
REQ-017 COMMIT: bcd_out SHALL take scratch and done SHALL be 1 for exactly this cycle; next state IDLE.
REQ-018 Latency: start accepted at edge k SHALL give done high during cycle k+N+1, with bcd_out valid from that cycle on.
REQ-019 busy SHALL be 1 in SHIFT and COMMIT, and 0 in IDLE.
REQ-020 start while busy=1 SHALL be ignored, with no queuing.
REQ-021 start asserted on the cycle after COMMIT SHALL be accepted (back-to-back conversions).
REQ-022 Overflow: if the captured value is >9999 (reachable only for N>=14), COMMIT SHALL load bcd_out=16'h9999 and set overflow=1; otherwise it SHALL set overflow=0.
REQ-023 bcd_out and overflow SHALL hold their values between commits; the display SHALL show the previous result during a conversion.
REQ-024 Prescaler: counts 0..DIV-1 continuously, independent of the FSM; at DIV-1 it SHALL wrap to 0 and advance the scan index.
REQ-025 Scan index SHALL be 2 bits, sequence 0,1,2,3,0, ...; wrap from 3 to 0 with no skipped cycle.
REQ-026 digit_sel SHALL equal ~(4'b0001 << index), and digit_code SHALL equal bcd_out nibble[index]; both SHALL be registered, so they update together one cycle after the index changes.
REQ-027 Exactly one digit_sel bit SHALL be low at all times after reset.

Reset
REQ-028 While rst=1 at a clock edge: FSM to IDLE; busy=0, done=0, overflow=0; bcd_out=16'h0000; prescaler=0; index=0; digit_sel=4'b1110; digit_code=4'h0.
REQ-029 rst SHALL take priority over start and over any in-progress conversion.
REQ-030 An aborted conversion SHALL NOT produce done and SHALL NOT update bcd_out.

Verification
REQ-031 N=10: bin_in=10'd999 with a 1-cycle start -> busy for 11 cycles, done once at k+11, bcd_out=16'h0999, overflow=0.
REQ-032 N=10: bin_in=1023 -> bcd_out=16'h1023; then bin_in=0 back-to-back -> bcd_out=16'h0000, 11 cycles after the second start.
REQ-033 N=14: bin_in=14'd12345 -> bcd_out=16'h9999, overflow=1; then bin_in=42 -> bcd_out=16'h0042, overflow=0.
REQ-034 start pulsed at cycles k+3 and k+7 during a conversion -> ignored; a single done at k+N+1 with the first value.
REQ-035 rst asserted at k+5 of a conversion -> no done, bcd_out=0, busy=0 on the next cycle; a new start then completes normally.
REQ-036 DIV=4, bcd_out=16'h1234 -> digit_sel steps 1110,1101,1011,0111 every 4 cycles with digit_code 4,3,2,1; wraps to 1110; never zero or multiple-low.

Source files
------------

// File: rtl/bcd_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : bcd_scan_ctrl_if
// Purpose  : Bundles the conversion handshake and display outputs of
//            bcd_scan_ctrl. The requester side uses the master modport.
//            The converter side uses the slave modport.
// Ports    : start_i      - conversion request
//            bin_in_i     - unsigned binary value, N bits
//            busy_o       - conversion in progress
//            done_o       - one-cycle pulse when a result is committed
//            overflow_o   - committed value was clamped to 9999
//            bcd_out_o    - committed result {thou, hund, tens, units}
//            digit_code_o - BCD digit of the scanned position
//            digit_sel_o  - active-low one-hot digit enable
// Revision : 1.0 - initial release
// ============================================================================
interface bcd_scan_ctrl_if #(
  parameter int N = 10
);
  logic           start_i;
  logic [N-1:0]   bin_in_i;
  logic           busy_o;
  logic           done_o;
  logic           overflow_o;
  logic [15:0]    bcd_out_o;
  logic [3:0]     digit_code_o;
  logic [3:0]     digit_sel_o;

  modport master (
    output start_i, bin_in_i,
    input  busy_o, done_o, overflow_o, bcd_out_o, digit_code_o, digit_sel_o
  );

  modport slave (
    input  start_i, bin_in_i,
    output busy_o, done_o, overflow_o, bcd_out_o, digit_code_o, digit_sel_o
  );
endinterface
`default_nettype wire

// File: rtl/bcd_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bcd_scan_ctrl
// Purpose  : Converts an N-bit unsigned value to 4-digit BCD with the
//            shift-and-add-3 method, one bit per clock. It also scans the
//            committed result onto a multiplexed 7-segment display.
// Ports    : clk - clock, rising edge
//            rst - synchronous active-high reset
//            bus - bcd_scan_ctrl_if.slave. Instantiate the interface with
//                  the same N as this module.
// Params   : N   - binary input width (4..14)
//            DIV - scan prescaler period in clk cycles (2..2^20)
// Revision : 1.0 - initial release
// ============================================================================
module bcd_scan_ctrl #(
  parameter int N   = 10,
  parameter int DIV = 50000
) (
  input  logic            clk,
  input  logic            rst,
  bcd_scan_ctrl_if.slave  bus
);

  localparam int CW = $clog2(N + 1);
  localparam int PW = $clog2(DIV);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    shift_q, shift_d;
  logic [15:0]     scratch_q, scratch_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ovf_cap_q, ovf_cap_d;
  logic [15:0]     bcd_q, bcd_d;
  logic            ovf_q, ovf_d;
  // Adjusted scratch. Bit 15 would be shifted out, so only 15 bits are kept.
  logic [14:0]     adj;
  logic [15:0]     shifted;

  logic [PW-1:0]   pre_q;
  logic [1:0]      idx_q;
  logic [3:0]      sel_q;
  logic [3:0]      code_q;

  // Add-3 correction: each nibble that is 5 or more gets 3 added before the shift.
  always_comb begin
    adj = scratch_q[14:0];
    for (int i = 0; i < 3; i++) begin
      if (scratch_q[i*4 +: 4] >= 4'd5)
        adj[i*4 +: 4] = scratch_q[i*4 +: 4] + 4'd3;
    end
    if (scratch_q[15:12] >= 4'd5)
      adj[14:12] = 3'(scratch_q[15:12] + 4'd3);
    shifted = {adj, shift_q[N-1]};
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    ovf_cap_d = ovf_cap_q;
    bcd_d     = bcd_q;
    ovf_d     = ovf_q;
    case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          shift_d   = bus.bin_in_i;
          scratch_d = 16'h0000;
          cnt_d     = CW'(N);
          ovf_cap_d = (14'(bus.bin_in_i) > 14'd9999);
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        scratch_d = shifted;
        shift_d   = shift_q << 1;
        cnt_d     = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          // Register the result on the edge that enters COMMIT.
          // This way bcd_out is already valid in the cycle where done is high.
          bcd_d   = ovf_cap_q ? 16'h9999 : shifted;
          ovf_d   = ovf_cap_q;
          state_d = COMMIT;
        end
      end
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      scratch_q <= 16'h0000;
      cnt_q     <= '0;
      ovf_cap_q <= 1'b0;
      bcd_q     <= 16'h0000;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      ovf_cap_q <= ovf_cap_d;
      bcd_q     <= bcd_d;
      ovf_q     <= ovf_d;
    end
  end

  // The display scanner is free-running and independent of the converter.
  // Select and code are registered from the same index, so they move together.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q  <= '0;
      idx_q  <= 2'd0;
      sel_q  <= 4'b1110;
      code_q <= 4'h0;
    end else begin
      if (pre_q == PW'(DIV - 1)) begin
        pre_q <= '0;
        idx_q <= idx_q + 2'd1;
      end else begin
        pre_q <= pre_q + 1'b1;
      end
      sel_q  <= ~(4'b0001 << idx_q);
      code_q <= bcd_q[{idx_q, 2'b00} +: 4];
    end
  end

  assign bus.busy_o       = (state_q != IDLE);
  assign bus.done_o       = (state_q == COMMIT);
  assign bus.overflow_o   = ovf_q;
  assign bus.bcd_out_o    = bcd_q;
  assign bus.digit_sel_o  = sel_q;
  assign bus.digit_code_o = code_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_scan_ctrl
// Purpose  : Self-checking bench for bcd_scan_ctrl. It uses one N=10/DIV=3
//            instance and one N=14/DIV=4 instance. Expected results come from
//            decimal arithmetic on the input value.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_scan_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bcd_scan_ctrl_if #(.N(10)) if10 ();
  bcd_scan_ctrl_if #(.N(14)) if14 ();

  bcd_scan_ctrl #(.N(10), .DIV(3)) dut10 (.clk(clk), .rst(rst), .bus(if10.slave));
  bcd_scan_ctrl #(.N(14), .DIV(4)) dut14 (.clk(clk), .rst(rst), .bus(if14.slave));

  int total = 0;
  int bad   = 0;

  // sel picks which instance the tasks drive and observe: 0 -> N=10, 1 -> N=14.
  logic        sel = 1'b0;
  logic        m_busy, m_done, m_ovf;
  logic [15:0] m_bcd;
  logic [3:0]  m_dsel, m_code;
  assign m_busy = sel ? if14.busy_o       : if10.busy_o;
  assign m_done = sel ? if14.done_o       : if10.done_o;
  assign m_ovf  = sel ? if14.overflow_o   : if10.overflow_o;
  assign m_bcd  = sel ? if14.bcd_out_o    : if10.bcd_out_o;
  assign m_dsel = sel ? if14.digit_sel_o  : if10.digit_sel_o;
  assign m_code = sel ? if14.digit_code_o : if10.digit_code_o;

  logic [15:0] prev_bcd [2];
  logic        prev_ovf [2];

  function automatic logic [15:0] ref_bcd(input int v);
    if (v > 9999) return 16'h9999;
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  task automatic set_start(input logic s, input int v);
    if (sel) begin
      if14.start_i  = s;
      if14.bin_in_i = 14'(v);
    end else begin
      if10.start_i  = s;
      if10.bin_in_i = 10'(v);
    end
  endtask

  // Call this in a post-edge interval while the selected DUT is idle.
  // Start is then accepted at the next edge.
  task automatic kick(input int v);
    set_start(1'b1, v);
    @(posedge clk); #1;
    set_start(1'b0, v);
  endtask

  // Interval i is the i-th sample taken after the acceptance edge.
  // Done is due in interval L (L = N), and busy should be high for L+1 intervals.
  task automatic wait_done(input int v, input bit poke, input string name);
    int L, ld, busyc, donec;
    bit held;
    logic [15:0] exp;
    logic e_ovf;
    L = sel ? 14 : 10;
    exp = ref_bcd(v);
    e_ovf = (v > 9999);
    ld = -1; busyc = 0; donec = 0; held = 1'b1;
    for (int i = 0; i <= L; i++) begin
      if (poke) set_start((i == 2 || i == 6), int'($urandom_range(0, 1023)));
      if (m_busy === 1'b1) busyc++;
      if (m_done === 1'b1) begin
        donec++;
        if (ld < 0) begin
          ld = i;
          total++;
          if (m_bcd !== exp) begin
            bad++;
            $display("FAIL %s bcd: got %h want %h (in %0d)", name, m_bcd, exp, v);
          end
          total++;
          if (m_ovf !== e_ovf) begin
            bad++;
            $display("FAIL %s ovf: got %b want %b (in %0d)", name, m_ovf, e_ovf, v);
          end
        end
      end else if (m_bcd !== prev_bcd[sel] || m_ovf !== prev_ovf[sel]) begin
        held = 1'b0;
      end
      @(posedge clk); #1;
    end
    set_start(1'b0, 0);
    total++;
    if (ld != L) begin
      bad++;
      $display("FAIL %s latency: got %0d want %0d", name, ld, L);
    end
    total++;
    if (donec != 1) begin
      bad++;
      $display("FAIL %s done count: got %0d want 1", name, donec);
    end
    total++;
    if (busyc != L + 1) begin
      bad++;
      $display("FAIL %s busy cycles: got %0d want %0d", name, busyc, L + 1);
    end
    total++;
    if (!held) begin
      bad++;
      $display("FAIL %s hold: previous result got 0 want 1 (kept during conversion)", name);
    end
    total++;
    if (m_busy !== 1'b0 || m_done !== 1'b0 || m_bcd !== exp || m_ovf !== e_ovf) begin
      bad++;
      $display("FAIL %s idle after: got busy=%b done=%b bcd=%h ovf=%b want 0 0 %h %b",
               name, m_busy, m_done, m_bcd, m_ovf, exp, e_ovf);
    end
    prev_bcd[sel] = exp;
    prev_ovf[sel] = e_ovf;
  endtask

  task automatic check_quiet(input int cycles, input string name);
    int hits = 0;
    for (int i = 0; i < cycles; i++) begin
      if (m_done !== 1'b0 || m_busy !== 1'b0) hits++;
      @(posedge clk); #1;
    end
    total++;
    if (hits != 0) begin
      bad++;
      $display("FAIL %s quiet: got %0d busy/done cycles want 0", name, hits);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_start(1'b0, 0);
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (if10.busy_o !== 1'b0 || if10.done_o !== 1'b0 || if10.overflow_o !== 1'b0 ||
        if10.bcd_out_o !== 16'h0000 || if10.digit_sel_o !== 4'b1110 || if10.digit_code_o !== 4'h0) begin
      bad++;
      $display("FAIL reset n10: got busy=%b done=%b ovf=%b bcd=%h sel=%b code=%h want 0 0 0 0000 1110 0",
               if10.busy_o, if10.done_o, if10.overflow_o, if10.bcd_out_o, if10.digit_sel_o, if10.digit_code_o);
    end
    total++;
    if (if14.busy_o !== 1'b0 || if14.done_o !== 1'b0 || if14.overflow_o !== 1'b0 ||
        if14.bcd_out_o !== 16'h0000 || if14.digit_sel_o !== 4'b1110 || if14.digit_code_o !== 4'h0) begin
      bad++;
      $display("FAIL reset n14: got busy=%b done=%b ovf=%b bcd=%h sel=%b code=%h want 0 0 0 0000 1110 0",
               if14.busy_o, if14.done_o, if14.overflow_o, if14.bcd_out_o, if14.digit_sel_o, if14.digit_code_o);
    end
    rst = 1'b0;
    prev_bcd[0] = 16'h0; prev_bcd[1] = 16'h0;
    prev_ovf[0] = 1'b0;  prev_ovf[1] = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_convert();
    int v;
    sel = 1'b0;
    kick(999);
    wait_done(999, 1'b0, "conv999");
    for (int k = 0; k < 6; k++) begin
      v = int'($urandom_range(0, 1023));
      kick(v);
      wait_done(v, 1'b0, "rand10");
    end
    sel = 1'b1;
    for (int k = 0; k < 6; k++) begin
      v = int'($urandom_range(0, 16383));
      kick(v);
      wait_done(v, 1'b0, "rand14");
    end
  endtask

  task automatic test_back_to_back();
    sel = 1'b0;
    kick(1023);
    wait_done(1023, 1'b0, "b2b_first");
    kick(0);
    wait_done(0, 1'b0, "b2b_second");
  endtask

  task automatic test_overflow();
    int vals [5] = '{12345, 42, 9999, 10000, 16383};
    sel = 1'b1;
    foreach (vals[i]) begin
      kick(vals[i]);
      wait_done(vals[i], 1'b0, "ovf14");
    end
  endtask

  task automatic test_ignore_start();
    sel = 1'b0;
    kick(555);
    wait_done(555, 1'b1, "ignore");
    check_quiet(20, "ignore");
  endtask

  task automatic test_abort();
    sel = 1'b0;
    kick(777);
    repeat (4) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++;
    if (m_busy !== 1'b0 || m_done !== 1'b0 || m_bcd !== 16'h0000) begin
      bad++;
      $display("FAIL abort: got busy=%b done=%b bcd=%h want 0 0 0000", m_busy, m_done, m_bcd);
    end
    prev_bcd[0] = 16'h0; prev_bcd[1] = 16'h0;
    prev_ovf[0] = 1'b0;  prev_ovf[1] = 1'b0;
    check_quiet(20, "abort");
    kick(321);
    wait_done(321, 1'b0, "after_abort");
  endtask

  task automatic test_scan(input logic s, input int v);
    int div, last_p, last_t, changes, p, bad_hot;
    logic [15:0] r;
    logic [3:0]  ds, dc;
    sel = s;
    div = s ? 4 : 3;
    kick(v);
    wait_done(v, 1'b0, "scan_load");
    @(posedge clk); #1;
    r = ref_bcd(v);
    last_p = -1; last_t = -1; changes = 0; bad_hot = 0;
    for (int t = 0; t < div * 4 * 3; t++) begin
      ds = m_dsel;
      dc = m_code;
      if ($countones(~ds) != 1) bad_hot++;
      p = 0;
      for (int b = 0; b < 4; b++) if (ds[b] == 1'b0) p = b;
      total++;
      if (dc !== r[p*4 +: 4]) begin
        bad++;
        $display("FAIL scan code t=%0d: got %h want %h (sel %b)", t, dc, r[p*4 +: 4], ds);
      end
      if (last_p >= 0 && p != last_p) begin
        changes++;
        total++;
        if (p != (last_p + 1) % 4) begin
          bad++;
          $display("FAIL scan order: got pos %0d want %0d", p, (last_p + 1) % 4);
        end
        if (last_t >= 0) begin
          total++;
          if (t - last_t != div) begin
            bad++;
            $display("FAIL scan period: got %0d want %0d", t - last_t, div);
          end
        end
        last_t = t;
      end
      last_p = p;
      @(posedge clk); #1;
    end
    total++;
    if (bad_hot != 0) begin
      bad++;
      $display("FAIL scan onehot: got %0d bad cycles want 0", bad_hot);
    end
    total++;
    if (changes < 10) begin
      bad++;
      $display("FAIL scan steps: got %0d want >=10", changes);
    end
  endtask

  initial begin
    if10.start_i = 1'b0; if10.bin_in_i = '0;
    if14.start_i = 1'b0; if14.bin_in_i = '0;
    test_reset();
    test_convert();
    test_back_to_back();
    test_overflow();
    test_ignore_start();
    test_abort();
    test_scan(1'b1, 1234);
    test_scan(1'b0, 987);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
